controller_shift_register: RTL and testbench

Player-side responder for the NES controller port: models a standard joypad's 8-bit parallel-in/serial-out shift register. It runs on the console clock and takes the latch and shift-clock signals that the top level drives towards the controller. It returns serial button data on the line that the console samples as controller 1 input. Raw button inputs are synchronised and debounced before they are loaded.

---
 rtl/controller_shift_register.sv | 96 +++++++++
 tb/tb_controller_shift_register.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/controller_shift_register.sv
// NES joypad responder: synchronised, debounced buttons parallel-loaded into an
// 8-bit shift register that is clocked out serially by the console shift clock.
module controller_shift_register #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic [7:0] i_buttons,
   input  logic       i_latch,
   input  logic       i_shift_clk,
   output logic       o_data,
   output logic [7:0] o_debug_buttons,
   output logic [3:0] o_debug_shift_count
);

   localparam int unsigned NUM_BUTTONS = 8;
   localparam int unsigned CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned SHIFT_W     = 4;

   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(8);
   localparam logic [SHIFT_W-1:0] SHIFT_ONE = SHIFT_W'(1);

   logic [NUM_BUTTONS-1:0] sync1;
   logic [NUM_BUTTONS-1:0] sync2;
   logic [NUM_BUTTONS-1:0] stable;
   logic [CNT_W-1:0]       db_cnt [NUM_BUTTONS];

   logic                   clk_prev;
   logic                   shift_rise;
   logic [7:0]             sr;
   logic [SHIFT_W-1:0]     count;

   // Two-flop synchroniser for the asynchronous button levels
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= i_buttons;
         sync2 <= sync1;
      end
   end

   // Per-button debounce: accept a level only after it differs long enough
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         stable <= '0;
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   assign shift_rise = i_shift_clk & ~clk_prev;

   // Shift clock idles high, so the edge detector resets high to avoid a false rise
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         clk_prev <= 1'b1;
      end else begin
         clk_prev <= i_shift_clk;
      end
   end

   // Latch dominates a coincident shift; ones fill in behind the shifted bits
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         sr    <= 8'h00;
         count <= '0;
      end else if (i_latch) begin
         sr    <= stable;
         count <= '0;
      end else if (shift_rise) begin
         sr    <= {1'b1, sr[7:1]};
         count <= (count == SHIFT_MAX) ? SHIFT_MAX : count + SHIFT_ONE;
      end
   end

   assign o_data              = sr[0];
   assign o_debug_buttons     = stable;
   assign o_debug_shift_count = count;

endmodule

// File: tb/tb_controller_shift_register.sv
// Scoreboard bench for controller_shift_register: stimulus queues expected
// output values, an independent monitor pops and compares them.
module tb_controller_shift_register;

   localparam int unsigned SEL_DATA  = 0;
   localparam int unsigned SEL_BTN   = 1;
   localparam int unsigned SEL_COUNT = 2;

   typedef struct {
      string       name;
      int unsigned sel;
      logic [7:0]  val;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] buttons;
   logic       latch;
   logic       shift_clk;
   logic       data;
   logic [7:0] debug_buttons;
   logic [3:0] debug_shift_count;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   controller_shift_register #(.DEBOUNCE_CYCLES(4)) dut (
      .i_clk               (clk),
      .i_reset_n           (reset_n),
      .i_buttons           (buttons),
      .i_latch             (latch),
      .i_shift_clk         (shift_clk),
      .o_data              (data),
      .o_debug_buttons     (debug_buttons),
      .o_debug_shift_count (debug_shift_count)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_out(input string name, input int unsigned sel, input logic [7:0] val);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.val  = val;
      sb.push_back(e);
   endtask

   // Low 2 cycles (read the bit), high 2 cycles (rise shifts)
   task automatic shift_pulse(input string name, input logic exp_bit);
      shift_clk = 1'b0;
      tick(2);
      expect_out(name, SEL_DATA, {7'b0, exp_bit});
      shift_clk = 1'b1;
      tick(2);
   endtask

   // Monitor: outputs are stable between edges; compare mid-low-phase
   initial begin
      exp_t        e;
      logic [7:0]  act;
      forever begin
         @(negedge clk);
         #3;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
               SEL_DATA:  act = {7'b0, data};
               SEL_BTN:   act = debug_buttons;
               default:   act = {4'b0, debug_shift_count};
            endcase
            n_vec++;
            if (act !== e.val) begin
               n_miss++;
               $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd_pattern;
      reset_n   = 1'b0;
      buttons   = 8'h00;
      latch     = 1'b0;
      shift_clk = 1'b1;
      tick(2);
      expect_out("reset_data", SEL_DATA, 8'h00);
      expect_out("reset_btn", SEL_BTN, 8'h00);
      expect_out("reset_count", SEL_COUNT, 8'h00);
      reset_n = 1'b1;
      tick(3);
      expect_out("release_no_shift", SEL_COUNT, 8'h00);

      // Full read of 8'h81 (A and Right)
      buttons = 8'h81;
      tick(5);
      expect_out("btn_latency_before", SEL_BTN, 8'h00);
      tick(1);
      expect_out("btn_latency_at", SEL_BTN, 8'h81);
      latch = 1'b1;
      tick(1);
      latch = 1'b0;
      expect_out("load_data", SEL_DATA, 8'h01);
      expect_out("load_count", SEL_COUNT, 8'h00);
      rd_pattern = 8'h81;
      for (int i = 0; i < 12; i++) begin
         shift_pulse($sformatf("read_bit%0d", i + 1), (i < 8) ? rd_pattern[i] : 1'b1);
      end
      expect_out("read_count_sat", SEL_COUNT, 8'h08);

      // Start bit toggled every 3 cycles never settles
      for (int i = 0; i < 10; i++) begin
         buttons[3] = ~buttons[3];
         tick(3);
         expect_out($sformatf("glitch%0d", i), SEL_BTN, 8'h81);
      end
      buttons[3] = 1'b1;
      tick(5);
      expect_out("start_hold_before", SEL_BTN, 8'h81);
      tick(1);
      expect_out("start_hold_at", SEL_BTN, 8'h89);

      // Latch held: shifts ignored, data follows debounced A
      latch     = 1'b1;
      buttons   = 8'h88;
      shift_clk = 1'b0;
      tick(1);
      expect_out("hold_data0", SEL_DATA, 8'h01);
      expect_out("hold_count0", SEL_COUNT, 8'h00);
      shift_clk = 1'b1;
      tick(2);
      expect_out("hold_data1", SEL_DATA, 8'h01);
      expect_out("hold_count1", SEL_COUNT, 8'h00);
      shift_clk = 1'b0;
      tick(2);
      expect_out("hold_data2", SEL_DATA, 8'h01);
      shift_clk = 1'b1;
      tick(2);
      expect_out("hold_data3", SEL_DATA, 8'h00);
      expect_out("hold_count3", SEL_COUNT, 8'h00);
      shift_clk = 1'b0;
      tick(2);
      expect_out("hold_data4", SEL_DATA, 8'h00);
      shift_clk = 1'b1;
      tick(2);
      expect_out("hold_data5", SEL_DATA, 8'h00);
      expect_out("hold_count5", SEL_COUNT, 8'h00);
      latch = 1'b0;

      // Latch coincident with a shift-clock rise
      buttons = 8'h02;
      tick(6);
      expect_out("b_debounced", SEL_BTN, 8'h02);
      shift_pulse("pre_bit1", 1'b0);
      shift_pulse("pre_bit2", 1'b0);
      shift_pulse("pre_bit3", 1'b0);
      expect_out("pre_count", SEL_COUNT, 8'h03);
      shift_clk = 1'b0;
      tick(2);
      latch     = 1'b1;
      shift_clk = 1'b1;
      tick(1);
      latch = 1'b0;
      expect_out("simul_data", SEL_DATA, 8'h00);
      expect_out("simul_count", SEL_COUNT, 8'h00);
      tick(1);
      shift_pulse("simul_read_a", 1'b0);
      expect_out("simul_after_data", SEL_DATA, 8'h01);
      expect_out("simul_after_count", SEL_COUNT, 8'h01);

      // Reset mid-operation
      latch = 1'b1;
      tick(1);
      latch = 1'b0;
      shift_pulse("mid_bit1", 1'b0);
      shift_pulse("mid_bit2", 1'b1);
      shift_pulse("mid_bit3", 1'b0);
      shift_pulse("mid_bit4", 1'b0);
      shift_pulse("mid_bit5", 1'b0);
      expect_out("mid_count", SEL_COUNT, 8'h05);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      expect_out("mid_rst_data", SEL_DATA, 8'h00);
      expect_out("mid_rst_count", SEL_COUNT, 8'h00);
      expect_out("mid_rst_btn", SEL_BTN, 8'h00);
      tick(5);
      expect_out("mid_rst_lat_before", SEL_BTN, 8'h00);
      tick(1);
      expect_out("mid_rst_lat_at", SEL_BTN, 8'h02);

      // Shift clock low at reset release: first rise shifts
      reset_n   = 1'b0;
      shift_clk = 1'b0;
      tick(1);
      reset_n = 1'b1;
      tick(2);
      expect_out("low_rel_count0", SEL_COUNT, 8'h00);
      shift_clk = 1'b1;
      tick(1);
      expect_out("low_rel_count1", SEL_COUNT, 8'h01);
      expect_out("low_rel_data", SEL_DATA, 8'h00);

      tick(2);
      for (int i = 0; i < 5 && sb.size() > 0; i++) begin
         tick(1);
      end
      if (sb.size() > 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
